// File: rtl/line_mem_responder.sv
// Line-addressed memory responder for the 128-bit cache line interface.
// Each accepted request completes after a fixed LATENCY with a one-cycle mem_ready pulse.
module line_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 4
) (
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
   localparam int         DEPTH    = 2 ** ADDR_W;

   state_t              state, state_d;
   logic [7:0]          cnt, cnt_d;
   logic                cap_write;
   logic [ADDR_W-1:0]   cap_addr;
   logic [127:0]        cap_wdata;
   logic                capture;
   logic                ready_d;
   logic                rd_load;
   logic                wr_commit;
   logic [127:0]        mem_array [DEPTH];

   // Upper address bits alias onto the same lines by design.
   logic                unused_addr_bits;
   assign unused_addr_bits = ^mem_addr[27:ADDR_W];

   assign busy = (state != IDLE);

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      capture   = 1'b0;
      ready_d   = 1'b0;
      rd_load   = 1'b0;
      wr_commit = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read || mem_write) begin
               capture = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt != 8'd0) begin
               cnt_d = cnt - 8'd1;
            end else begin
               state_d   = RESP;
               ready_d   = 1'b1;
               rd_load   = ~cap_write;
               wr_commit = cap_write;
            end
         end
         // Requests still held during the ready cycle are deliberately not sampled.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         mem_ready <= ready_d;
         if (capture) begin
            cap_write <= mem_write;
            cap_addr  <= mem_addr[ADDR_W-1:0];
            cap_wdata <= mem_wdata;
         end
         if (rd_load) begin
            mem_rdata <= mem_array[cap_addr];
         end
      end
   end

   // NOTE: the storage array has no reset; a reset during WAIT forces IDLE so wr_commit never fires.
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         mem_array[cap_addr] <= cap_wdata;
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: vector table, hand corner cases,
// and randomized traffic against an associative-array line store model.
module tb_line_mem_responder;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         proc_reset;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready, busy;

   logic         d1_read, d1_write;
   logic [27:0]  d1_addr;
   logic [127:0] d1_wdata, d1_rdata;
   logic         d1_ready, d1_busy;

   int checks   = 0;
   int failures = 0;

   logic [127:0] ref_mem [int];
   logic [127:0] ref_rdata;

   always #5 clk = ~clk;

   line_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
      .clk(clk), .proc_reset(proc_reset),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
   );

   line_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
      .clk(clk), .proc_reset(proc_reset),
      .mem_read(d1_read), .mem_write(d1_write),
      .mem_addr(d1_addr), .mem_wdata(d1_wdata),
      .mem_rdata(d1_rdata), .mem_ready(d1_ready), .busy(d1_busy)
   );

   typedef struct {
      logic         wr;
      logic         rd;
      logic [27:0]  addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issues one request on the LATENCY=4 instance and returns how many cycles until mem_ready.
   task automatic txn(input logic wr, input logic rd, input logic [27:0] addr,
                      input logic [127:0] wd, output int cycles, output logic [127:0] rdata);
      @(negedge clk);
      mem_write = wr; mem_read = rd; mem_addr = addr; mem_wdata = wd;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!mem_ready && cycles < 50);
      rdata = mem_rdata;
      mem_write = 1'b0; mem_read = 1'b0;
      mem_addr  = 28'($urandom); mem_wdata = {4{$urandom}};
      @(negedge clk);
      check("ready_single_pulse", 128'(mem_ready), 128'd0);
      check("idle_after_resp", 128'(busy), 128'd0);
   endtask

   // Model: writes take priority, upper address bits alias, reads update the held rdata.
   function automatic logic [127:0] model_apply(input logic wr, input logic rd,
                                                input logic [27:0] addr, input logic [127:0] wd);
      int idx = int'(addr % 256);
      if (wr) ref_mem[idx] = wd;
      else if (rd) ref_rdata = ref_mem[idx];
      return ref_rdata;
   endfunction

   initial begin
      vec_t         vecs [6];
      int           cyc;
      logic [127:0] rd_val;
      logic [127:0] exp_v;
      logic [15:0]  ready_mask;
      int           keys [$];

      vecs[0] = '{1'b1, 1'b0, 28'h0000010, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 128'h0};
      vecs[1] = '{1'b0, 1'b1, 28'h0000010, 128'h0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0};
      vecs[2] = '{1'b1, 1'b1, 28'h0000005, 128'h1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0};
      vecs[3] = '{1'b0, 1'b1, 28'h0000005, 128'h0, 128'h1};
      vecs[4] = '{1'b0, 1'b1, 28'h0000105, 128'h0, 128'h1};
      vecs[5] = '{1'b1, 1'b0, 28'h0000007, 128'h55, 128'h1};

      proc_reset = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
      d1_read = 1'b0; d1_write = 1'b0; d1_addr = '0; d1_wdata = '0;
      ref_rdata = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", 128'(mem_ready), 128'd0);
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_rdata", mem_rdata, 128'd0);
      proc_reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, cyc, rd_val);
         exp_v = model_apply(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d_latency", i), 128'(cyc), 128'(LAT + 1));
         check($sformatf("vec%0d_rdata", i), rd_val, vecs[i].exp_rdata);
         check($sformatf("vec%0d_model", i), rd_val, exp_v);
      end

      // rdata holds after the ready cycle with no request pending
      txn(1'b0, 1'b1, 28'h0000010, '0, cyc, rd_val);
      exp_v = model_apply(1'b0, 1'b1, 28'h0000010, '0);
      @(negedge clk);
      check("rdata_hold", mem_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);

      // read held high across RESP: pulses LAT+2 apart, no double acknowledge
      @(negedge clk);
      mem_read = 1'b1; mem_addr = 28'h0000005;
      ready_mask = '0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         ready_mask[k] = mem_ready;
         if (k == 11) begin
            check("held_read_rdata", mem_rdata, 128'h1);
            mem_read = 1'b0;
         end
      end
      check("held_read_pulses", 128'(ready_mask), 128'(16'h0820));
      @(negedge clk);
      check("held_read_idle", 128'({mem_ready, busy}), 128'd0);
      exp_v = model_apply(1'b0, 1'b1, 28'h5, '0);

      // reset during WAIT of a write: no commit, no ready, rdata cleared
      txn(1'b0, 1'b1, 28'h0000010, '0, cyc, rd_val);
      @(negedge clk);
      mem_write = 1'b1; mem_addr = 28'h0000007; mem_wdata = 128'hAA;
      @(negedge clk);
      check("pre_reset_busy", 128'(busy), 128'd1);
      proc_reset = 1'b1;
      #1;
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_ready", 128'(mem_ready), 128'd0);
      check("abort_rdata", mem_rdata, 128'd0);
      mem_write = 1'b0;
      repeat (2) @(negedge clk);
      proc_reset = 1'b0;
      ready_mask = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         ready_mask[k] = mem_ready;
      end
      check("abort_no_late_ready", 128'(ready_mask), 128'd0);
      ref_rdata = '0;
      txn(1'b0, 1'b1, 28'h0000007, '0, cyc, rd_val);
      exp_v = model_apply(1'b0, 1'b1, 28'h7, '0);
      check("abort_no_commit", rd_val, 128'h55);
      check("abort_model", rd_val, exp_v);

      // randomized traffic; reads only target lines the model knows
      for (int n = 0; n < 40; n++) begin
         logic         wr, rd;
         logic [27:0]  a;
         logic [127:0] wd;
         keys.delete();
         foreach (ref_mem[key]) keys.push_back(key);
         wr = ($urandom_range(0, 1) == 1);
         rd = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
         wd = {$urandom, $urandom, $urandom, $urandom};
         if (wr) a = 28'($urandom_range(0, 15) + 256 * $urandom_range(0, 3));
         else    a = 28'(keys[$urandom_range(0, keys.size() - 1)] + 256 * $urandom_range(0, 1000));
         txn(wr, rd, a, wd, cyc, rd_val);
         exp_v = model_apply(wr, rd, a, wd);
         check($sformatf("rand%0d_latency", n), 128'(cyc), 128'(LAT + 1));
         check($sformatf("rand%0d_rdata", n), rd_val, exp_v);
      end

      // LATENCY=1 instance: write, then read with busy for exactly two cycles
      @(negedge clk);
      d1_write = 1'b1; d1_addr = 28'h0000003; d1_wdata = 128'h1234;
      repeat (2) @(negedge clk);
      d1_write = 1'b0;
      repeat (2) @(negedge clk);
      d1_read = 1'b1;
      ready_mask = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         ready_mask[k]     = d1_ready;
         ready_mask[k + 8] = d1_busy;
         if (k == 2) begin
            check("lat1_rdata", d1_rdata, 128'h1234);
            d1_read = 1'b0;
         end
      end
      check("lat1_ready", 128'(ready_mask[7:0]), 128'(8'h04));
      check("lat1_busy", 128'(ready_mask[15:8]), 128'(8'h06));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
